// File: rtl/finalip_axil_pkg.sv
// Shared constants and address-decode helpers for the FinalIP AXI4-Lite register bank.
// Contents: AXI response codes, register count, word-address LSB, in_range/reg_index.
// Addresses are handled as 32-bit values; narrower buses are zero-extended by the caller.
package finalip_axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int NUM_REGS = 4;
    localparam int ADDR_LSB = 2;

    // Only byte offsets 0x0..0xF decode to a register; any higher bit set is an error.
    function automatic logic in_range(input logic [31:0] addr);
        return (addr >> (ADDR_LSB + 2)) == 32'd0;
    endfunction

    // Word index within the bank; byte offset bits [1:0] are deliberately dropped.
    function automatic logic [1:0] reg_index(input logic [31:0] addr);
        return addr[ADDR_LSB+1:ADDR_LSB];
    endfunction

endpackage

// File: rtl/axil_hold_slot.sv
// One-entry valid/ready holding register used to park an AXI address or data beat.
// Latency: a beat accepted on edge N is visible on full/dat after edge N.
// Backpressure: in_rdy drops while the slot is occupied or reset is high; clr empties it.
//
// Ports: clk/rst (sync active-high), in_vld/in_rdy/in_dat (producer side),
//        clr (consumer pops the entry), full/dat (held entry).
module axil_hold_slot #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_vld,
    output logic         in_rdy,
    input  logic [W-1:0] in_dat,
    input  logic         clr,
    output logic         full,
    output logic [W-1:0] dat
);

    logic         full_q;
    logic [W-1:0] dat_q;

    // Ready depends only on slot state and reset, never on in_vld.
    assign in_rdy = !full_q && !rst;
    assign full   = full_q;
    assign dat    = dat_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q <= 1'b0;
            dat_q  <= '0;
        end else begin
            // clr only fires while full, and loading only happens while empty,
            // so the two never collide on the same edge.
            if (in_vld && in_rdy) begin
                full_q <= 1'b1;
                dat_q  <= in_dat;
            end else if (clr) begin
                full_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/finalip_s00_axi_regs.sv
// AXI4-Lite slave with four 32-bit registers exported to FinalIP user logic.
// Latency: write commits one edge after the later of AW/W handshakes; read data one edge after AR.
// Backpressure: AW/W stall while their slot is full; AR stalls while a read response is pending.
//
// Ports: s00_axi_* AXI4-Lite slave (sync active-high reset s00_axi_areset),
//        usr_regs = register contents (reg n at [32n+31:32n]),
//        usr_wr_pulse = one-cycle strobe per register on each committed write.
module finalip_s00_axi_regs
    import finalip_axil_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int C_NUM_REGS         = 4
) (
    input  logic                           s00_axi_aclk,
    input  logic                           s00_axi_areset,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]  s00_axi_awaddr,
    input  logic [2:0]                     s00_axi_awprot,
    input  logic                           s00_axi_awvalid,
    output logic                           s00_axi_awready,
    input  logic [31:0]                    s00_axi_wdata,
    input  logic [3:0]                     s00_axi_wstrb,
    input  logic                           s00_axi_wvalid,
    output logic                           s00_axi_wready,
    output logic [1:0]                     s00_axi_bresp,
    output logic                           s00_axi_bvalid,
    input  logic                           s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]  s00_axi_araddr,
    input  logic [2:0]                     s00_axi_arprot,
    input  logic                           s00_axi_arvalid,
    output logic                           s00_axi_arready,
    output logic [31:0]                    s00_axi_rdata,
    output logic [1:0]                     s00_axi_rresp,
    output logic                           s00_axi_rvalid,
    input  logic                           s00_axi_rready,
    output logic [32*C_NUM_REGS-1:0]       usr_regs,
    output logic [C_NUM_REGS-1:0]          usr_wr_pulse
);

    localparam int AW = C_S_AXI_ADDR_WIDTH;

    // Protection bits carry no meaning for this bank.
    logic unused_prot;
    assign unused_prot = ^{s00_axi_awprot, s00_axi_arprot};

    // ---------------- AW / W holding slots ----------------
    logic          aw_full, w_full;
    logic [AW-1:0] aw_addr;
    logic [35:0]   w_dat;     // {strb, data}
    logic          commit;

    axil_hold_slot #(.W(AW)) u_aw_slot (
        .clk    (s00_axi_aclk),
        .rst    (s00_axi_areset),
        .in_vld (s00_axi_awvalid),
        .in_rdy (s00_axi_awready),
        .in_dat (s00_axi_awaddr),
        .clr    (commit),
        .full   (aw_full),
        .dat    (aw_addr)
    );

    axil_hold_slot #(.W(36)) u_w_slot (
        .clk    (s00_axi_aclk),
        .rst    (s00_axi_areset),
        .in_vld (s00_axi_wvalid),
        .in_rdy (s00_axi_wready),
        .in_dat ({s00_axi_wstrb, s00_axi_wdata}),
        .clr    (commit),
        .full   (w_full),
        .dat    (w_dat)
    );

    // ---------------- write commit ----------------
    logic [31:0] regs [NUM_REGS];
    logic [31:0] aw_addr32, ar_addr32;
    logic        aw_ok, ar_ok;
    logic [1:0]  aw_idx, ar_idx;
    logic        bvalid_q;
    logic [1:0]  bresp_q;
    logic [NUM_REGS-1:0] pulse_q;

    assign aw_addr32 = 32'(aw_addr);
    assign ar_addr32 = 32'(s00_axi_araddr);
    assign aw_ok     = in_range(aw_addr32);
    assign ar_ok     = in_range(ar_addr32);
    assign aw_idx    = reg_index(aw_addr32);
    assign ar_idx    = reg_index(ar_addr32);

    // Committing while the previous response is being accepted keeps bvalid
    // high back-to-back instead of inserting a bubble.
    assign commit = aw_full && w_full && (!bvalid_q || s00_axi_bready);

    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            bvalid_q <= 1'b0;
            bresp_q  <= RESP_OKAY;
            pulse_q  <= '0;
            for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
        end else begin
            pulse_q <= '0;
            if (commit) begin
                bvalid_q <= 1'b1;
                if (aw_ok) begin
                    bresp_q         <= RESP_OKAY;
                    pulse_q[aw_idx] <= 1'b1;
                    for (int b = 0; b < 4; b++) begin
                        if (w_dat[32+b]) regs[aw_idx][8*b +: 8] <= w_dat[8*b +: 8];
                    end
                end else begin
                    bresp_q <= RESP_SLVERR;
                end
            end else if (s00_axi_bready) begin
                bvalid_q <= 1'b0;
            end
        end
    end

    assign s00_axi_bvalid = bvalid_q;
    assign s00_axi_bresp  = bresp_q;
    assign usr_wr_pulse   = pulse_q;

    always_comb begin
        usr_regs = '0;
        for (int r = 0; r < NUM_REGS; r++) usr_regs[32*r +: 32] = regs[r];
    end

    // ---------------- read path ----------------
    logic        rvalid_q;
    logic [31:0] rdata_q;
    logic [1:0]  rresp_q;

    // One outstanding read: the next AR is taken only after R is consumed,
    // which caps throughput at one read every two cycles.
    assign s00_axi_arready = !rvalid_q && !s00_axi_areset;

    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
        end else begin
            if (s00_axi_arvalid && s00_axi_arready) begin
                // regs is sampled before this edge's write lands: pre-write value.
                rvalid_q <= 1'b1;
                rdata_q  <= ar_ok ? regs[ar_idx] : 32'd0;
                rresp_q  <= ar_ok ? RESP_OKAY : RESP_SLVERR;
            end else if (s00_axi_rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    assign s00_axi_rvalid = rvalid_q;
    assign s00_axi_rdata  = rdata_q;
    assign s00_axi_rresp  = rresp_q;

endmodule

// File: tb/tb_finalip_s00_axi_regs.sv
module tb_finalip_s00_axi_regs;

    logic         tb_ACLK = 1'b0;
    logic         areset;
    logic [31:0]  awaddr, araddr, wdata, rdata;
    logic [2:0]   awprot, arprot;
    logic         awvalid, awready, wvalid, wready, bvalid, bready;
    logic         arvalid, arready, rvalid, rready;
    logic [3:0]   wstrb, usr_wr_pulse;
    logic [1:0]   bresp, rresp;
    logic [127:0] usr_regs;

    int total = 0;
    int bad   = 0;
    logic [31:0] model [4];

    always #5 tb_ACLK = ~tb_ACLK;

    finalip_s00_axi_regs dut (
        .s00_axi_aclk    (tb_ACLK),
        .s00_axi_areset  (areset),
        .s00_axi_awaddr  (awaddr),
        .s00_axi_awprot  (awprot),
        .s00_axi_awvalid (awvalid),
        .s00_axi_awready (awready),
        .s00_axi_wdata   (wdata),
        .s00_axi_wstrb   (wstrb),
        .s00_axi_wvalid  (wvalid),
        .s00_axi_wready  (wready),
        .s00_axi_bresp   (bresp),
        .s00_axi_bvalid  (bvalid),
        .s00_axi_bready  (bready),
        .s00_axi_araddr  (araddr),
        .s00_axi_arprot  (arprot),
        .s00_axi_arvalid (arvalid),
        .s00_axi_arready (arready),
        .s00_axi_rdata   (rdata),
        .s00_axi_rresp   (rresp),
        .s00_axi_rvalid  (rvalid),
        .s00_axi_rready  (rready),
        .usr_regs        (usr_regs),
        .usr_wr_pulse    (usr_wr_pulse)
    );

    // ---------------- reference model ----------------
    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    function automatic bit addr_ok(input logic [31:0] a);
        return a < 32'h10;
    endfunction

    function automatic logic [127:0] model_flat();
        return {model[3], model[2], model[1], model[0]};
    endfunction

    function automatic logic [3:0] exp_pulse(input logic [31:0] a);
        logic [3:0] p;
        p = 4'b0000;
        if (addr_ok(a)) p[a[3:2]] = 1'b1;
        return p;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge tb_ACLK);
        #1;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] resp, output logic [3:0] pulse);
        int  n;
        bit  aw_done, w_done, aw_hs, w_hs;
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        aw_done = 0; w_done = 0; n = 0;
        while (!(aw_done && w_done) && n < 50) begin
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            tick(); n++;
            if (aw_hs) begin awvalid = 1'b0; aw_done = 1; end
            if (w_hs)  begin wvalid  = 1'b0; w_done  = 1; end
        end
        n = 0;
        while (!bvalid && n < 50) begin tick(); n++; end
        if (!bvalid) begin
            total++; bad++;
            $display("FAIL write_timeout addr=%h bvalid=%b required 1", a, bvalid);
        end
        resp  = bresp;
        pulse = usr_wr_pulse;
        bready = 1'b1;
        tick();
        bready = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
        int n;
        araddr = a; arvalid = 1'b1; rready = 1'b0; n = 0;
        while (!arready && n < 50) begin tick(); n++; end
        tick();
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 50) begin tick(); n++; end
        if (!rvalid) begin
            total++; bad++;
            $display("FAIL read_timeout addr=%h rvalid=%b required 1", a, rvalid);
        end
        d = rdata; resp = rresp;
        rready = 1'b1;
        tick();
        rready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #490;
        total++; if ({awready, wready, arready} !== 3'b000) begin bad++; $display("FAIL rst_readies got=%b required 000", {awready, wready, arready}); end
        total++; if ({bvalid, rvalid} !== 2'b00) begin bad++; $display("FAIL rst_valids got=%b required 00", {bvalid, rvalid}); end
        total++; if ({bresp, rresp, rdata} !== 36'd0) begin bad++; $display("FAIL rst_resp_data got=%h required 0", {bresp, rresp, rdata}); end
        total++; if (usr_regs !== 128'd0 || usr_wr_pulse !== 4'd0) begin bad++; $display("FAIL rst_usr got=%h/%b required 0", usr_regs, usr_wr_pulse); end
        #10 areset = 1'b0;
        tick();
        total++; if ({awready, wready, arready} !== 3'b111) begin bad++; $display("FAIL post_rst_readies got=%b required 111", {awready, wready, arready}); end
    endtask

    task automatic test_basic_rw();
        logic [31:0] av [4];
        logic [31:0] dv [4];
        logic [31:0] rd;
        logic [1:0]  rs;
        logic [3:0]  p;
        av = '{32'h0, 32'h4, 32'h8, 32'hC};
        dv = '{32'h0101FFFF, 32'habcd0001, 32'hdead0011, 32'hbeef0011};
        for (int i = 0; i < 4; i++) begin
            do_write(av[i], dv[i], 4'hF, rs, p);
            model[i] = dv[i];
            total++; if (rs !== 2'b00) begin bad++; $display("FAIL basic_bresp[%0d] got=%b required 00", i, rs); end
            total++; if (p !== exp_pulse(av[i])) begin bad++; $display("FAIL basic_pulse[%0d] got=%b required %b", i, p, exp_pulse(av[i])); end
            do_read(av[i], rd, rs);
            total++; if (rs !== 2'b00) begin bad++; $display("FAIL basic_rresp[%0d] got=%b required 00", i, rs); end
            total++; if (rd !== dv[i]) begin bad++; $display("FAIL basic_rdata[%0d] got=%h required %h", i, rd, dv[i]); end
        end
        total++; if (usr_regs !== model_flat()) begin bad++; $display("FAIL basic_usr_regs got=%h required %h", usr_regs, model_flat()); end
    endtask

    task automatic test_w_before_aw();
        wdata = 32'h12345678; wstrb = 4'hF; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        tick(); tick();
        total++; if (bvalid !== 1'b0 || usr_wr_pulse !== 4'b0) begin bad++; $display("FAIL wfirst_early_commit bvalid=%b pulse=%b required 0/0000", bvalid, usr_wr_pulse); end
        total++; if (usr_regs !== model_flat()) begin bad++; $display("FAIL wfirst_early_regs got=%h required %h", usr_regs, model_flat()); end
        awaddr = 32'h4; awvalid = 1'b1;
        tick();                      // AW handshake edge
        awvalid = 1'b0;
        total++; if (bvalid !== 1'b0 || usr_wr_pulse !== 4'b0) begin bad++; $display("FAIL wfirst_at_aw bvalid=%b pulse=%b required 0/0000", bvalid, usr_wr_pulse); end
        tick();                      // commit edge
        model[1] = 32'h12345678;
        total++; if (bvalid !== 1'b1 || bresp !== 2'b00) begin bad++; $display("FAIL wfirst_b bvalid=%b bresp=%b required 1/00", bvalid, bresp); end
        total++; if (usr_wr_pulse !== 4'b0010) begin bad++; $display("FAIL wfirst_pulse got=%b required 0010", usr_wr_pulse); end
        total++; if (usr_regs !== model_flat()) begin bad++; $display("FAIL wfirst_regs got=%h required %h", usr_regs, model_flat()); end
        bready = 1'b1;
        tick();
        bready = 1'b0;
        total++; if (usr_wr_pulse !== 4'b0000 || bvalid !== 1'b0) begin bad++; $display("FAIL wfirst_after pulse=%b bvalid=%b required 0000/0", usr_wr_pulse, bvalid); end
    endtask

    task automatic test_strobe();
        logic [31:0] rd;
        logic [1:0]  rs;
        logic [3:0]  p;
        do_write(32'h8, 32'h0000AA00, 4'b0010, rs, p);
        model[2] = merge(model[2], 32'h0000AA00, 4'b0010);
        do_read(32'h8, rd, rs);
        total++; if (rd !== 32'hdeadAA11) begin bad++; $display("FAIL strobe_rdata got=%h required deadaa11", rd); end
        total++; if (usr_regs !== model_flat()) begin bad++; $display("FAIL strobe_regs got=%h required %h", usr_regs, model_flat()); end
    endtask

    task automatic test_out_of_range();
        logic [31:0] rd;
        logic [1:0]  rs;
        logic [3:0]  p;
        do_write(32'h10, 32'hFFFFFFFF, 4'hF, rs, p);
        total++; if (rs !== 2'b10) begin bad++; $display("FAIL oor_bresp got=%b required 10", rs); end
        total++; if (p !== 4'b0000) begin bad++; $display("FAIL oor_pulse got=%b required 0000", p); end
        do_read(32'h10, rd, rs);
        total++; if (rs !== 2'b10 || rd !== 32'd0) begin bad++; $display("FAIL oor_read rresp=%b rdata=%h required 10/0", rs, rd); end
        total++; if (usr_regs !== model_flat()) begin bad++; $display("FAIL oor_regs got=%h required %h", usr_regs, model_flat()); end
    endtask

    task automatic test_back_to_back();
        logic [1:0] rs;
        logic [3:0] p;
        int  n;
        bit  aw_hs, w_hs;
        // First write with bready low: response stays pending.
        awaddr = 32'h0; wdata = 32'h5A5A5A5A; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        n = 0;
        while (!bvalid && n < 20) begin tick(); n++; end
        model[0] = 32'h5A5A5A5A;
        // Second write issued while the first B is stalled.
        awaddr = 32'hC; wdata = 32'hC0FFEE00; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            tick();
            if (aw_hs) awvalid = 1'b0;
            if (w_hs)  wvalid  = 1'b0;
            total++; if (bvalid !== 1'b1) begin bad++; $display("FAIL b2b_hold[%0d] bvalid=%b required 1", c, bvalid); end
        end
        total++; if (usr_regs !== model_flat()) begin bad++; $display("FAIL b2b_early_regs got=%h required %h", usr_regs, model_flat()); end
        bready = 1'b1;
        tick();                      // first B handshake == second commit
        model[3] = 32'hC0FFEE00;
        total++; if (bvalid !== 1'b1) begin bad++; $display("FAIL b2b_second_b bvalid=%b required 1", bvalid); end
        total++; if (usr_wr_pulse !== 4'b1000) begin bad++; $display("FAIL b2b_pulse got=%b required 1000", usr_wr_pulse); end
        total++; if (usr_regs !== model_flat()) begin bad++; $display("FAIL b2b_regs got=%h required %h", usr_regs, model_flat()); end
        tick();
        bready = 1'b0;
        total++; if (bvalid !== 1'b0) begin bad++; $display("FAIL b2b_drain bvalid=%b required 0", bvalid); end
        do_write(32'h4, 32'h0, 4'h0, rs, p);   // strobe-less write: register untouched
        total++; if (rs !== 2'b00 || p !== 4'b0010) begin bad++; $display("FAIL b2b_nostrb resp=%b pulse=%b required 00/0010", rs, p); end
    endtask

    task automatic test_random();
        logic [31:0] a, d, rd;
        logic [3:0]  s, p;
        logic [1:0]  rs;
        for (int i = 0; i < 24; i++) begin
            a = $urandom_range(0, 15);
            if ($urandom_range(0, 4) == 0) a = a | (32'h10 << $urandom_range(0, 27));
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) begin
                do_write(a, d, s, rs, p);
                if (addr_ok(a)) model[a[3:2]] = merge(model[a[3:2]], d, s);
                total++; if (rs !== (addr_ok(a) ? 2'b00 : 2'b10) || p !== exp_pulse(a)) begin bad++; $display("FAIL rnd_write[%0d] addr=%h resp=%b pulse=%b required %b/%b", i, a, rs, p, addr_ok(a) ? 2'b00 : 2'b10, exp_pulse(a)); end
            end else begin
                do_read(a, rd, rs);
                total++; if (rs !== (addr_ok(a) ? 2'b00 : 2'b10) || rd !== (addr_ok(a) ? model[a[3:2]] : 32'd0)) begin bad++; $display("FAIL rnd_read[%0d] addr=%h resp=%b data=%h required %b/%h", i, a, rs, rd, addr_ok(a) ? 2'b00 : 2'b10, addr_ok(a) ? model[a[3:2]] : 32'd0); end
            end
        end
        total++; if (usr_regs !== model_flat()) begin bad++; $display("FAIL rnd_regs got=%h required %h", usr_regs, model_flat()); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        logic [1:0]  rs;
        logic [3:0]  p;
        araddr = 32'h0; arvalid = 1'b1; rready = 1'b0;
        tick();
        arvalid = 1'b0;
        total++; if (rvalid !== 1'b1) begin bad++; $display("FAIL mid_rvalid_pre got=%b required 1", rvalid); end
        wdata = 32'h77777777; wstrb = 4'hF; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        total++; if (wready !== 1'b0) begin bad++; $display("FAIL mid_w_held wready=%b required 0", wready); end
        areset = 1'b1;
        #1;
        total++; if ({awready, wready, arready} !== 3'b000) begin bad++; $display("FAIL mid_rst_readies got=%b required 000", {awready, wready, arready}); end
        tick();
        areset = 1'b0;
        for (int r = 0; r < 4; r++) model[r] = 32'd0;
        total++; if ({rvalid, bvalid} !== 2'b00) begin bad++; $display("FAIL mid_valids got=%b required 00", {rvalid, bvalid}); end
        total++; if (usr_regs !== 128'd0 || rdata !== 32'd0) begin bad++; $display("FAIL mid_clear regs=%h rdata=%h required 0", usr_regs, rdata); end
        tick();
        total++; if ({awready, wready, arready} !== 3'b111) begin bad++; $display("FAIL mid_readies got=%b required 111", {awready, wready, arready}); end
        // The discarded W must not pair with a fresh AW.
        total++; if (bvalid !== 1'b0 || usr_regs !== 128'd0) begin bad++; $display("FAIL mid_no_ghost bvalid=%b regs=%h required 0", bvalid, usr_regs); end
        do_write(32'h8, 32'h13572468, 4'hF, rs, p);
        model[2] = 32'h13572468;
        do_read(32'h8, rd, rs);
        total++; if (rd !== model[2] || rs !== 2'b00) begin bad++; $display("FAIL mid_recover data=%h resp=%b required %h/00", rd, rs, model[2]); end
    endtask

    initial begin
        areset = 1'b1;
        awaddr = '0; awprot = 3'b0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arprot = 3'b0; arvalid = 1'b0; rready = 1'b0;
        for (int r = 0; r < 4; r++) model[r] = 32'd0;
        test_reset();
        test_basic_rw();
        test_w_before_aw();
        test_strobe();
        test_out_of_range();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout time=%0t required completion", $time);
        $fatal(1, "timeout");
    end

endmodule
